// File: rtl/despachador_solicitudes.sv
// Elevator request dispatcher: walks the pending-request bitmap in SCAN order,
// moves the car floor by floor, opens the door and pulses a per-floor clear mask.
module despachador_solicitudes #(
  parameter int N_PISOS  = 8,
  parameter int T_VIAJE  = 4,
  parameter int T_PUERTA = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PISOS-1:0]         solicitudes,
  output logic [N_PISOS-1:0]         atendido,
  output logic [$clog2(N_PISOS)-1:0] piso_actual,
  output logic                       subiendo,
  output logic                       moviendo,
  output logic                       puerta_abierta
);

  localparam int PW    = $clog2(N_PISOS);
  localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] SUBIENDO = 2'd1;
  localparam logic [1:0] BAJANDO  = 2'd2;
  localparam logic [1:0] PUERTA   = 2'd3;

  logic [1:0]         state_reg;
  logic [TW-1:0]      timer_reg;
  logic [PW:0]        piso_ext;
  logic [PW-1:0]      piso_sig;
  logic [N_PISOS-1:0] arriba_bits, abajo_bits, lejos_arriba_bits, lejos_abajo_bits;
  logic [N_PISOS-1:0] onehot_actual, onehot_sig;
  logic               arriba, abajo, en_piso, mas_alla;

  assign piso_ext = {1'b0, piso_actual};

  // "lejos" terms look past the floor about to be reached, deciding whether to keep going.
  genvar gi;
  generate
    for (gi = 0; gi < N_PISOS; gi++) begin : g_piso
      localparam logic [PW:0] IDX = (PW + 1)'(gi);
      assign arriba_bits[gi]       = solicitudes[gi] && (IDX > piso_ext);
      assign abajo_bits[gi]        = solicitudes[gi] && (IDX < piso_ext);
      assign lejos_arriba_bits[gi] = solicitudes[gi] && (IDX > piso_ext + (PW + 1)'(1));
      assign lejos_abajo_bits[gi]  = solicitudes[gi] && (IDX + (PW + 1)'(1) < piso_ext);
    end
  endgenerate

  assign arriba        = |arriba_bits;
  assign abajo         = |abajo_bits;
  assign en_piso       = solicitudes[piso_actual];
  assign piso_sig      = subiendo ? piso_actual + PW'(1) : piso_actual - PW'(1);
  assign mas_alla      = subiendo ? |lejos_arriba_bits : |lejos_abajo_bits;
  assign onehot_actual = N_PISOS'(1) << piso_actual;
  assign onehot_sig    = N_PISOS'(1) << piso_sig;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= REPOSO;
      timer_reg      <= '0;
      piso_actual    <= '0;
      subiendo       <= 1'b1;
      moviendo       <= 1'b0;
      puerta_abierta <= 1'b0;
      atendido       <= '0;
    end else begin
      atendido <= '0;
      case (state_reg)
        REPOSO: begin
          timer_reg <= '0;
          if (en_piso) begin
            state_reg      <= PUERTA;
            puerta_abierta <= 1'b1;
            atendido       <= onehot_actual;
          end else if (arriba && (subiendo || !abajo)) begin
            state_reg <= SUBIENDO;
            subiendo  <= 1'b1;
            moviendo  <= 1'b1;
          end else if (abajo) begin
            state_reg <= BAJANDO;
            subiendo  <= 1'b0;
            moviendo  <= 1'b1;
          end
        end
        SUBIENDO, BAJANDO: begin
          if (timer_reg == TW'(T_VIAJE - 1)) begin
            timer_reg   <= '0;
            piso_actual <= piso_sig;
            if (solicitudes[piso_sig]) begin
              state_reg      <= PUERTA;
              moviendo       <= 1'b0;
              puerta_abierta <= 1'b1;
              atendido       <= onehot_sig;
            end else if (!mas_alla) begin
              state_reg <= REPOSO;
              moviendo  <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          // The request is still visible while its own clear pulse is out; only a later press reopens.
          if (en_piso && (atendido == '0)) begin
            timer_reg <= '0;
            atendido  <= onehot_actual;
          end else if (timer_reg == TW'(T_PUERTA - 1)) begin
            state_reg      <= REPOSO;
            puerta_abierta <= 1'b0;
            timer_reg      <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_despachador_solicitudes.sv
// Bench for despachador_solicitudes: models the registrador (set on press, clear one
// edge after atendido) and scoreboards every expected atendido pulse with its cycle.
module tb_despachador_solicitudes;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] solicitudes = 8'h00;
  logic [7:0] atendido;
  logic [2:0] piso_actual;
  logic       subiendo, moviendo, puerta_abierta;

  despachador_solicitudes #(.N_PISOS(8), .T_VIAJE(4), .T_PUERTA(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .solicitudes    (solicitudes),
    .atendido       (atendido),
    .piso_actual    (piso_actual),
    .subiendo       (subiendo),
    .moviendo       (moviendo),
    .puerta_abierta (puerta_abierta)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         c0;
  logic [7:0] pend     = 8'h00;
  logic [7:0] clr_prev = 8'h00;
  logic [7:0] sb_mask[$];
  int         sb_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [7:0] mask, input int at_cyc);
    sb_mask.push_back(mask);
    sb_cyc.push_back(at_cyc);
  endtask

  // One clock: sample after the edge, score any atendido pulse, update the request register.
  task automatic step();
    logic [7:0] m;
    int         c;
    @(posedge clk);
    #1;
    cyc++;
    if (atendido != 8'h00) begin
      if (sb_mask.size() == 0) begin
        check("atendido_unexpected", {24'h0, atendido}, 32'h0);
      end else begin
        m = sb_mask.pop_front();
        c = sb_cyc.pop_front();
        $display("cycle %0d: atendido=%02h (expected %02h at cycle %0d)", cyc, atendido, m, c);
        check("atendido_mask", {24'h0, atendido}, {24'h0, m});
        check("atendido_cycle", cyc, c);
      end
    end
    pend     = pend & ~clr_prev;
    clr_prev = atendido;
    if (reset) begin
      pend     = 8'h00;
      clr_prev = 8'h00;
    end
    solicitudes = pend;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [7:0] mask);
    pend        = pend | mask;
    solicitudes = pend;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_piso"}, {29'h0, piso_actual}, 32'd0);
    check({tag, "_subiendo"}, {31'h0, subiendo}, 32'd1);
    check({tag, "_moviendo"}, {31'h0, moviendo}, 32'd0);
    check({tag, "_puerta"}, {31'h0, puerta_abierta}, 32'd0);
    check({tag, "_atendido"}, {24'h0, atendido}, 32'd0);
  endtask

  initial begin
    // Reset from power-up
    run(2);
    check_idle("reset_init");
    reset = 1'b0;
    run(3);
    check_idle("idle_no_req");

    // Request at the current floor
    c0 = cyc;
    press(8'h01);
    expect_pulse(8'h01, c0 + 1);
    step();
    check("cur_puerta_open", {31'h0, puerta_abierta}, 32'd1);
    run(5);
    check("cur_puerta_last", {31'h0, puerta_abierta}, 32'd1);
    step();
    check("cur_puerta_closed", {31'h0, puerta_abierta}, 32'd0);

    // Single trip up to floor 3
    c0 = cyc;
    press(8'h08);
    expect_pulse(8'h08, c0 + 13);
    step();
    check("trip_moviendo", {31'h0, moviendo}, 32'd1);
    run(3);
    check("trip_piso_c4", {29'h0, piso_actual}, 32'd0);
    step();
    check("trip_piso_c5", {29'h0, piso_actual}, 32'd1);
    run(4);
    check("trip_piso_c9", {29'h0, piso_actual}, 32'd2);
    run(4);
    check("trip_piso_c13", {29'h0, piso_actual}, 32'd3);
    check("trip_puerta", {31'h0, puerta_abierta}, 32'd1);
    check("trip_stopped", {31'h0, moviendo}, 32'd0);
    run(6);
    check("trip_closed", {31'h0, puerta_abierta}, 32'd0);

    // Door reopen at floor 4
    c0 = cyc;
    press(8'h10);
    expect_pulse(8'h10, c0 + 5);
    run(5);
    check("reopen_piso", {29'h0, piso_actual}, 32'd4);
    run(2);
    press(8'h10);
    expect_pulse(8'h10, c0 + 8);
    run(6);
    check("reopen_still_open", {31'h0, puerta_abierta}, 32'd1);
    step();
    check("reopen_closed", {31'h0, puerta_abierta}, 32'd0);

    // Reset while idle at floor 4, then reset mid-travel at floor 2
    reset = 1'b1;
    run(2);
    check_idle("reset_floor4");
    reset = 1'b0;
    c0 = cyc;
    press(8'h40);
    run(9);
    check("mid_piso2", {29'h0, piso_actual}, 32'd2);
    check("mid_moviendo", {31'h0, moviendo}, 32'd1);
    step();
    reset = 1'b1;
    step();
    check("mid_reset_piso", {29'h0, piso_actual}, 32'd0);
    check("mid_reset_moviendo", {31'h0, moviendo}, 32'd0);
    check("mid_reset_atendido", {24'h0, atendido}, 32'd0);
    step();
    reset = 1'b0;
    run(4);
    check_idle("after_mid_reset");

    // SCAN order: moving up past floor 3 with floors 5 and 1 requested
    c0 = cyc;
    press(8'h20);
    expect_pulse(8'h20, c0 + 21);
    run(13);
    check("scan_piso3", {29'h0, piso_actual}, 32'd3);
    check("scan_moving_up", {30'h0, subiendo, moviendo}, 32'd3);
    press(8'h02);
    expect_pulse(8'h02, c0 + 44);
    run(8);
    check("scan_at5", {29'h0, piso_actual}, 32'd5);
    run(23);
    check("scan_at1", {29'h0, piso_actual}, 32'd1);
    check("scan_down", {31'h0, subiendo}, 32'd0);
    run(7);
    check("scan_closed", {31'h0, puerta_abierta}, 32'd0);

    check("sb_empty", sb_mask.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/despachador_solicitudes.md
Name: despachador_solicitudes

Overview:
- Consumer side of the request register: reads the pending-request bitmap that the registrador holds and moves the car floor by floor.
- Serves requests in SCAN order and opens the door at each served floor.
- Returns a one-cycle per-floor "atendido" mask so the registrador can clear served requests.
- Sits between the registrador and the motor/door drivers.

Parameters:
- N_PISOS, 8, number of floors; bitmap width.
- T_VIAJE, 4, clock cycles to travel one floor (>=1).
- T_PUERTA, 6, clock cycles the door stays open (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- solicitudes  input  N_PISOS  pending-request bitmap (bit i = floor i requested), level, from registrador.
- atendido  output  N_PISOS  one-hot clear pulse for the served floor, one cycle per service.
- piso_actual  output  $clog2(N_PISOS)  current floor.
- subiendo  output  1  direction flag (1 = up); retained while idle.
- moviendo  output  1  car travelling between floors.
- puerta_abierta  output  1  door open.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and takes priority at any state, including mid-travel and door-open.
- Reset values: state REPOSO, piso_actual=0, subiendo=1, moviendo=0, puerta_abierta=0, atendido=0, timer=0.
- Outputs are registered. moviendo=1 exactly in SUBIENDO/BAJANDO; puerta_abierta=1 exactly in PUERTA.
- Helper terms: arriba = any solicitudes bit above piso_actual; abajo = any bit below.
- REPOSO, evaluated each cycle:
  - If solicitudes[piso_actual] -> PUERTA.
  - Else if arriba and (subiendo or !abajo) -> SUBIENDO, subiendo=1.
  - Else if abajo -> BAJANDO, subiendo=0.
  - Else stay.
- SUBIENDO/BAJANDO:
  - timer counts 0..T_VIAJE-1.
  - At the edge where timer==T_VIAJE-1: piso_actual +/-1, timer=0.
  - At that same edge, test solicitudes[next floor]. If set -> PUERTA.
  - Else continue only if requests remain beyond next floor in the current direction; otherwise -> REPOSO (re-evaluate).
  - piso_actual never leaves 0..N_PISOS-1. Requests withdrawn mid-travel are handled by the arrival test.
- Latency: the request is sampled in REPOSO at cycle 0. SUBIENDO is entered at edge 1. Floor k above is reached at edge 1+k*T_VIAJE, and PUERTA is entered at that same edge.
- PUERTA:
  - On entry, atendido = one-hot(piso_actual) for exactly one cycle; timer=0.
  - Door stays open T_PUERTA cycles, then -> REPOSO with puerta_abierta=0.
  - If solicitudes[piso_actual] is asserted in any PUERTA cycle after the atendido cycle (new button press at this floor): restart the timer and pulse atendido again the next cycle.
  - Requests at other floors are ignored until REPOSO.
- SCAN direction policy: the current direction is preserved while requests remain ahead. Reversal happens only from REPOSO.
- atendido is never asserted outside PUERTA and is never multi-hot.
- solicitudes bits at or above N_PISOS do not exist. An all-zero solicitudes leaves the block idle indefinitely.

Test Plan:
All scenarios use N_PISOS=8, T_VIAJE=4, T_PUERTA=6.
- Reset check: assert reset 2 cycles in any state -> piso_actual=0, subiendo=1, moviendo=0, puerta_abierta=0, atendido=8'h00 on the next edge.
- Request at current floor: idle at floor 0, solicitudes=8'h01 at cycle 0 -> at edge 1 puerta_abierta=1 and atendido=8'h01 for one cycle; door stays open cycles 1-6; REPOSO at edge 7.
- Single trip up: idle at floor 0, solicitudes=8'h08 -> moviendo=1 from edge 1; piso_actual=1,2,3 at edges 5,9,13; PUERTA at edge 13 with atendido=8'h08.
- SCAN order: car moving up at floor 3, solicitudes=8'h22 (floors 5 and 1) -> serves floor 5 first (atendido=8'h20), then reverses and serves floor 1 (atendido=8'h02).
- Reset mid-travel: reset asserted while piso_actual=2 moving up -> next edge piso_actual=0, moviendo=0; no atendido pulse.
- Door reopen: door open at floor 4, solicitudes[4] re-asserted at door cycle 3 -> atendido=8'h10 pulses again; door remains open 6 more cycles.
